// File: rtl/sat_pkg.sv
// rtl/sat_pkg.sv - command encodings shared by the saturating accumulator
package sat_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_ADD   = 2'b00;
    localparam op_t OP_SUB   = 2'b01;
    localparam op_t OP_LOAD  = 2'b10;
    localparam op_t OP_CLEAR = 2'b11;

endpackage

// File: rtl/sat_addsub.sv
// rtl/sat_addsub.sv - combinational N-bit signed add/subtract with clamp to signed range
module sat_addsub #(
    parameter int N = 8
) (
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    input  logic                sub,
    output logic signed [N-1:0] y,
    output logic                sat
);

    localparam logic signed [N-1:0] MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] MIN = {1'b1, {(N-1){1'b0}}};

    logic signed [N:0] ax;
    logic signed [N:0] bx;
    logic signed [N:0] r;

    // One guard bit makes every sum/difference exact, including a - MIN.
    assign ax  = {a[N-1], a};
    assign bx  = {b[N-1], b};
    assign r   = sub ? (ax - bx) : (ax + bx);
    assign sat = r[N] ^ r[N-1];
    assign y   = sat ? (r[N] ? MIN : MAX) : r[N-1:0];

endmodule

// File: rtl/sat_accumulator.sv
// rtl/sat_accumulator.sv - multi-channel saturating accumulator with valid/ready handshakes
module sat_accumulator
    import sat_pkg::*;
#(
    parameter  int N   = 8,
    parameter  int CH  = 4,
    localparam int CHW = $clog2(CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CHW-1:0]      in_ch,
    input  op_t                 in_op,
    input  logic signed [N-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CHW-1:0]      out_ch,
    output logic signed [N-1:0] out_data,
    output logic                out_sat,
    output logic [CH-1:0]       sat_sticky,
    input  logic [CH-1:0]       sticky_clr
);

    localparam logic [CHW:0] CH_LIM = CH[CHW:0];

    logic signed [N-1:0] acc [CH];
    logic                accept;
    logic                ch_ok;
    logic signed [N-1:0] cur;
    logic signed [N-1:0] as_y;
    logic                as_sat;
    logic signed [N-1:0] res;
    logic                res_sat;
    logic [CH-1:0]       set_mask;

    // Single output register: a new command may enter only when the slot frees this edge.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign ch_ok    = ({1'b0, in_ch} < CH_LIM);
    assign cur      = ch_ok ? acc[in_ch] : '0;

    sat_addsub #(.N(N)) u_addsub (
        .a   (cur),
        .b   (in_data),
        .sub (in_op == OP_SUB),
        .y   (as_y),
        .sat (as_sat)
    );

    always_comb begin
        res     = '0;
        res_sat = 1'b0;
        case (in_op)
            OP_ADD, OP_SUB: begin
                res     = as_y;
                res_sat = as_sat;
            end
            OP_LOAD: res = in_data;
            default: res = '0;
        endcase
    end

    always_comb begin
        set_mask = '0;
        if (accept && ch_ok && res_sat) begin
            set_mask[in_ch] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                acc[i] <= '0;
            end
            out_valid  <= 1'b0;
            out_ch     <= '0;
            out_data   <= '0;
            out_sat    <= 1'b0;
            sat_sticky <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept && ch_ok) begin
                acc[in_ch] <= res;
                out_valid  <= 1'b1;
                out_ch     <= in_ch;
                out_data   <= res;
                out_sat    <= res_sat;
            end
            // A new saturation beats a same-cycle clear of the same bit.
            sat_sticky <= (sat_sticky & ~sticky_clr) | set_mask;
        end
    end

endmodule

// File: doc/sat_accumulator.md
# sat_accumulator

Multi-channel saturating two's-complement accumulator with valid/ready handshakes on input and output. Each accepted command adds to, subtracts from, loads or clears one channel's N-bit signed accumulator, clamping to the signed range instead of wrapping. It sits in the datapath wherever running sums must not wrap, and replaces single-shot combinational saturating adders with persistent per-channel state and overflow reporting.

## Interface
- N, 8, accumulator/data width in bits (≥2)
- CH, 4, number of independent channels (≥2)
- CHW, $clog2(CH), channel index width (localparam, derived, not overridable)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  command present
- in_ready  out  1  command accepted when in_valid && in_ready
- in_ch  in  CHW  target channel; values ≥ CH are ignored (command accepted, no state change, no output)
- in_op  in  2  00 ADD, 01 SUB, 10 LOAD, 11 CLEAR
- in_data  in  N  signed operand (ignored for CLEAR)
- out_valid  out  1  result present
- out_ready  in  1  result consumed when out_valid && out_ready
- out_ch  out  CHW  channel of the result
- out_data  out  N  new accumulator value of that channel
- out_sat  out  1  this command saturated
- sat_sticky  out  CH  per-channel sticky saturation flag
- sticky_clr  in  CH  per-channel write-1-to-clear for sat_sticky

## Operation
- MAX = 2^(N-1)-1, MIN = -2^(N-1).
- ADD: r = acc + data; SUB: r = acc - data; both computed in N+1 bits, sign-extended operands.
- Overflow when r[N] != r[N-1]; result is MAX if r[N]==0, else MIN; out_sat=1. Otherwise result = r[N-1:0], out_sat=0.
- SUB with data=MIN is exact in N+1 bits: acc ≥ 0 saturates to MAX; acc < 0 yields acc - MIN.
- LOAD: acc ← data, out_sat=0. CLEAR: acc ← 0, out_sat=0.
- On accept: channel acc updated the same edge; out_* registered with the result; sat_sticky[ch] set if out_sat.
- sat_sticky: set wins over sticky_clr on the same cycle for the same bit; clears on other bits proceed.
- Channels are independent; commands to one channel never alter another.

## Timing
- Reset values: all acc = 0, out_valid=0, out_ch=0, out_data=0, out_sat=0, sat_sticky=0. in_ready=1 in first cycle after reset release.
- in_ready = !out_valid || out_ready (combinational; single output register, no skid buffer).
- Latency: command accepted at edge k → out_valid=1 with result after edge k.
- Full throughput: back-to-back accepts with out_ready=1 every cycle; same-channel back-to-back commands each see the previous command's result (no hazard).
- Stall: out_valid && !out_ready holds out_* stable and in_ready=0; no acc changes until the result is consumed.
- Simultaneous consume and accept: old result leaves, new result loaded the same edge; out_valid stays 1.
- Out-of-range in_ch: accepted, out_valid goes/stays 0 unless a held result remains.
- Reset asserted mid-stream: pending output dropped, all state returns to reset values immediately (async).

## Structure
- Package sat_pkg: op encoding constants (OP_ADD, OP_SUB, OP_LOAD, OP_CLEAR), 2-bit op typedef.
- Sub-module sat_addsub (combinational, parameter N): inputs a, b, sub; outputs y, sat. Holds all width/clamp rules; top holds acc array, handshake and sticky logic.

## Test plan
- Reset, then ADD ch0 data=100 twice (N=8) -> out_data 100 (sat 0), then 127 (sat 1), sat_sticky=0001.
- LOAD ch1 -100, SUB ch1 data=50 -> out_data -128, out_sat=1; SUB ch2 (acc 0) data=-128 -> 127, sat 1.
- Interleave ch0..ch3 ADD 1 for 8 cycles, out_ready=1 -> one result per cycle, each channel ends at 2, sticky unchanged.
- Hold out_ready=0 two cycles with in_valid=1 -> in_ready=0, out_* stable, acc unchanged; release -> next result after one edge.
- Saturate ch3 and assert sticky_clr[3] same cycle -> sat_sticky[3]=1; clear next cycle -> 0.
- Assert rst while out_valid=1 and acc nonzero -> out_valid=0, all outputs 0; CLEAR/ADD afterwards starts from 0.
